// File: rtl/nasti_lite_read_arbiter.sv
// Round-robin arbiter sharing one NASTI-Lite read slave between NUM_MASTERS masters.
// Define NASTI_LITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module nasti_lite_read_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_TRANSACTION = 4,
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 8,
    parameter int LITE_DATA_WIDTH = 32,
    parameter int USER_WIDTH      = 1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]        m_ar_id,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_ar_addr,
    input  logic [NUM_MASTERS*3-1:0]               m_ar_prot,
    input  logic [NUM_MASTERS*4-1:0]               m_ar_qos,
    input  logic [NUM_MASTERS*4-1:0]               m_ar_region,
    input  logic [NUM_MASTERS*USER_WIDTH-1:0]      m_ar_user,
    input  logic [NUM_MASTERS-1:0]                 m_ar_valid,
    output logic [NUM_MASTERS-1:0]                 m_ar_ready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]        m_r_id,
    output logic [NUM_MASTERS*LITE_DATA_WIDTH-1:0] m_r_data,
    output logic [NUM_MASTERS*2-1:0]               m_r_resp,
    output logic [NUM_MASTERS*USER_WIDTH-1:0]      m_r_user,
    output logic [NUM_MASTERS-1:0]                 m_r_valid,
    input  logic [NUM_MASTERS-1:0]                 m_r_ready,
    output logic [ID_WIDTH-1:0]                    lite_ar_id,
    output logic [ADDR_WIDTH-1:0]                  lite_ar_addr,
    output logic [2:0]                             lite_ar_prot,
    output logic [3:0]                             lite_ar_qos,
    output logic [3:0]                             lite_ar_region,
    output logic [USER_WIDTH-1:0]                  lite_ar_user,
    output logic                                   lite_ar_valid,
    input  logic                                   lite_ar_ready,
    input  logic [ID_WIDTH-1:0]                    lite_r_id,
    input  logic [LITE_DATA_WIDTH-1:0]             lite_r_data,
    input  logic [1:0]                             lite_r_resp,
    input  logic [USER_WIDTH-1:0]                  lite_r_user,
    input  logic                                   lite_r_valid,
    output logic                                   lite_r_ready
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int PW = (MAX_TRANSACTION > 1) ? $clog2(MAX_TRANSACTION) : 1;
    localparam int CW = $clog2(MAX_TRANSACTION + 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t          state;
    logic [MW-1:0]   rr_ptr;
    logic [MW-1:0]   winner;
    logic            found;
    logic            grant;
    logic            r_hs;
    logic [MW-1:0]   fifo [2**PW];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   outstanding;
    logic [MW-1:0]   head;

    // First valid master at or after the pointer, searching cyclically.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_ar_valid[MW'(idx)]) begin
                found  = 1'b1;
                winner = MW'(idx);
            end
        end
    end

    // Uses the registered count, so an R completing this cycle frees a slot only next cycle.
    assign grant = (state == S_EMPTY) && found && (outstanding < CW'(MAX_TRANSACTION));

    always_comb begin
        m_ar_ready = '0;
        if (grant) m_ar_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_EMPTY;
            lite_ar_valid  <= 1'b0;
            lite_ar_id     <= '0;
            lite_ar_addr   <= '0;
            lite_ar_prot   <= '0;
            lite_ar_qos    <= '0;
            lite_ar_region <= '0;
            lite_ar_user   <= '0;
            rr_ptr         <= '0;
        end else begin
            case (state)
                S_EMPTY: if (grant) begin
                    lite_ar_id     <= m_ar_id[winner*ID_WIDTH +: ID_WIDTH];
                    lite_ar_addr   <= m_ar_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    lite_ar_prot   <= m_ar_prot[winner*3 +: 3];
                    lite_ar_qos    <= m_ar_qos[winner*4 +: 4];
                    lite_ar_region <= m_ar_region[winner*4 +: 4];
                    lite_ar_user   <= m_ar_user[winner*USER_WIDTH +: USER_WIDTH];
                    lite_ar_valid  <= 1'b1;
                    state          <= S_FULL;
`ifndef NASTI_LITE_ARB_FIXED_PRIO_EN
                    rr_ptr         <= (winner == MW'(NUM_MASTERS - 1)) ? '0 : winner + MW'(1);
`endif
                end
                S_FULL: if (lite_ar_ready) begin
                    lite_ar_valid <= 1'b0;
                    state         <= S_EMPTY;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // In-order grant FIFO: one entry per issued read, popped by its single R beat.
    assign head = fifo[rd_ptr];

    always_comb begin
        m_r_valid    = '0;
        lite_r_ready = 1'b0;
        if (outstanding != '0) begin
            m_r_valid[head] = lite_r_valid;
            lite_r_ready    = m_r_ready[head];
        end
    end

    assign r_hs = lite_r_valid && lite_r_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + PW'(1);
            if (r_hs)  rd_ptr <= rd_ptr + PW'(1);
            if (grant && !r_hs)      outstanding <= outstanding + CW'(1);
            else if (!grant && r_hs) outstanding <= outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) fifo[wr_ptr] <= winner;
    end

    assign m_r_id   = {NUM_MASTERS{lite_r_id}};
    assign m_r_data = {NUM_MASTERS{lite_r_data}};
    assign m_r_resp = {NUM_MASTERS{lite_r_resp}};
    assign m_r_user = {NUM_MASTERS{lite_r_user}};

endmodule

// File: tb/tb_nasti_lite_read_arbiter.sv
// Bench for nasti_lite_read_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model (grant order queue, slot flag, slave read queue).
module tb_nasti_lite_read_arbiter;
    localparam int NM = 2;
    localparam int MT = 4;
    localparam int IW = 1;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int UW = 1;

    logic                 clk;
    logic                 rstn;
    logic [NM*IW-1:0]     m_ar_id;
    logic [NM*AW-1:0]     m_ar_addr;
    logic [NM*3-1:0]      m_ar_prot;
    logic [NM*4-1:0]      m_ar_qos;
    logic [NM*4-1:0]      m_ar_region;
    logic [NM*UW-1:0]     m_ar_user;
    logic [NM-1:0]        m_ar_valid;
    logic [NM-1:0]        m_ar_ready;
    logic [NM*IW-1:0]     m_r_id;
    logic [NM*DW-1:0]     m_r_data;
    logic [NM*2-1:0]      m_r_resp;
    logic [NM*UW-1:0]     m_r_user;
    logic [NM-1:0]        m_r_valid;
    logic [NM-1:0]        m_r_ready;
    logic [IW-1:0]        lite_ar_id;
    logic [AW-1:0]        lite_ar_addr;
    logic [2:0]           lite_ar_prot;
    logic [3:0]           lite_ar_qos;
    logic [3:0]           lite_ar_region;
    logic [UW-1:0]        lite_ar_user;
    logic                 lite_ar_valid;
    logic                 lite_ar_ready;
    logic [IW-1:0]        lite_r_id;
    logic [DW-1:0]        lite_r_data;
    logic [1:0]           lite_r_resp;
    logic [UW-1:0]        lite_r_user;
    logic                 lite_r_valid;
    logic                 lite_r_ready;

    nasti_lite_read_arbiter #(
        .NUM_MASTERS(NM), .MAX_TRANSACTION(MT), .ID_WIDTH(IW),
        .ADDR_WIDTH(AW), .LITE_DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
        .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region), .m_ar_user(m_ar_user),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_user(m_r_user),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot),
        .lite_ar_qos(lite_ar_qos), .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
        .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
        .lite_r_id(lite_r_id), .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp),
        .lite_r_user(lite_r_user), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit              mdl_full;
    logic [AW-1:0]   mdl_addr;
    logic [IW-1:0]   mdl_id;
    int              mdl_ptr;
    int              mq_m[$];
    logic [AW-1:0]   mq_a[$];
    logic [AW-1:0]   sq[$];

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {8'hC3, a, ~a, 8'h5A};
    endfunction

    function automatic int onehot_idx(input logic [NM-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NM; i++) if (v == (NM'(1) << i)) r = i;
        return r;
    endfunction

    task automatic rand_payload();
        m_ar_id     = NM*IW'($urandom);
        m_ar_addr   = NM*AW'($urandom);
        m_ar_prot   = NM*3'($urandom);
        m_ar_qos    = NM*4'($urandom);
        m_ar_region = NM*4'($urandom);
        m_ar_user   = NM*UW'($urandom);
    endtask

    task automatic drive_r(input bit want, input logic [NM-1:0] rr);
        lite_r_valid = want && (sq.size() > 0);
        lite_r_data  = (sq.size() > 0) ? data_of(sq[0]) : DW'($urandom);
        lite_r_id    = IW'($urandom);
        lite_r_resp  = 2'($urandom);
        lite_r_user  = UW'($urandom);
        m_r_ready    = rr;
    endtask

    // One clock: called at negedge with inputs driven; compares outputs, advances the model.
    task automatic cycle_model(input string tag, output logic [NM-1:0] seen);
        int w, h, idx;
        bit grant, ar_hs, r_hs;
        logic [NM-1:0] e_ready, e_rvalid;
        logic e_lrr;
        #1;
        seen = m_ar_ready;
        w = -1;
        for (int k = 0; k < NM; k++) begin
            idx = (mdl_ptr + k) % NM;
            if (w < 0 && m_ar_valid[idx]) w = idx;
        end
        grant = !mdl_full && (mq_m.size() < MT) && (w >= 0);
        e_ready = '0;
        if (grant) e_ready[w] = 1'b1;
        e_rvalid = '0; e_lrr = 1'b0; h = -1;
        if (mq_m.size() > 0) begin
            h = mq_m[0];
            e_rvalid[h] = lite_r_valid;
            e_lrr = m_r_ready[h];
        end
        checks++;
        if (m_ar_ready !== e_ready) begin
            failures++;
            $display("FAIL %s ar_ready got=%b exp=%b", tag, m_ar_ready, e_ready);
        end
        checks++;
        if (lite_ar_valid !== mdl_full) begin
            failures++;
            $display("FAIL %s lite_ar_valid got=%b exp=%b", tag, lite_ar_valid, mdl_full);
        end
        if (mdl_full) begin
            checks++;
            if (lite_ar_addr !== mdl_addr || lite_ar_id !== mdl_id) begin
                failures++;
                $display("FAIL %s ar_payload got=%h/%h exp=%h/%h", tag, lite_ar_addr, lite_ar_id, mdl_addr, mdl_id);
            end
        end
        checks++;
        if (m_r_valid !== e_rvalid || lite_r_ready !== e_lrr) begin
            failures++;
            $display("FAIL %s r_route got=%b/%b exp=%b/%b", tag, m_r_valid, lite_r_ready, e_rvalid, e_lrr);
        end
        r_hs = lite_r_valid && e_lrr;
        if (r_hs) begin
            checks++;
            if (m_r_data[h*DW +: DW] !== data_of(mq_a[0])) begin
                failures++;
                $display("FAIL %s r_data m%0d got=%h exp=%h", tag, h, m_r_data[h*DW +: DW], data_of(mq_a[0]));
            end
        end
        ar_hs = mdl_full && lite_ar_ready;
        @(posedge clk);
        if (ar_hs) begin
            sq.push_back(mdl_addr);
            mdl_full = 1'b0;
        end
        if (grant) begin
            mdl_full = 1'b1;
            mdl_addr = m_ar_addr[w*AW +: AW];
            mdl_id   = m_ar_id[w*IW +: IW];
            mq_m.push_back(w);
            mq_a.push_back(mdl_addr);
`ifndef NASTI_LITE_ARB_FIXED_PRIO_EN
            mdl_ptr = (w + 1) % NM;
`endif
        end
        if (r_hs) begin
            void'(mq_m.pop_front());
            void'(mq_a.pop_front());
            void'(sq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn          = 1'b0;
        m_ar_valid    = '0;
        lite_ar_ready = 1'b0;
        lite_r_valid  = 1'b1;
        m_r_ready     = '1;
        #1;
        checks++;
        if (lite_ar_valid !== 1'b0 || lite_ar_addr !== '0 || m_ar_ready !== '0) begin
            failures++;
            $display("FAIL reset_ar got valid=%b addr=%h ready=%b exp 0/00/00", lite_ar_valid, lite_ar_addr, m_ar_ready);
        end
        checks++;
        if (m_r_valid !== '0 || lite_r_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_r got m_r_valid=%b lite_r_ready=%b exp 00/0", m_r_valid, lite_r_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        mdl_full = 1'b0; mdl_addr = '0; mdl_id = '0; mdl_ptr = 0;
        mq_m.delete(); mq_a.delete(); sq.delete();
        lite_r_valid = 1'b0;
    endtask

    task automatic drain();
        logic [NM-1:0] s;
        int n;
        n = 0;
        m_ar_valid    = '0;
        lite_ar_ready = 1'b1;
        while ((mdl_full || mq_m.size() > 0) && n < 50) begin
            drive_r(1'b1, '1);
            cycle_model("drain", s);
            n++;
        end
        checks++;
        if (mdl_full || mq_m.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp 0", mq_m.size());
        end
        lite_r_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive_r(1'b0, '1);
        lite_r_valid = 1'b1;
        #1;
        checks++;
        if (lite_r_ready !== 1'b0 || m_r_valid !== '0 || lite_ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_no_ack got lite_r_ready=%b m_r_valid=%b ar_valid=%b exp 0/00/0", lite_r_ready, m_r_valid, lite_ar_valid);
        end
        @(negedge clk);
        lite_r_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [NM-1:0] s;
        rand_payload();
        m_ar_addr[AW-1:0] = 8'h10;
        m_ar_valid    = 2'b01;
        lite_ar_ready = 1'b0;
        drive_r(1'b0, '1);
        cycle_model("single_req", s);
        checks++;
        if (s !== 2'b01) begin
            failures++;
            $display("FAIL single_grant got=%b exp=01", s);
        end
        m_ar_valid    = '0;
        lite_ar_ready = 1'b1;
        #1;
        checks++;
        if (lite_ar_valid !== 1'b1 || lite_ar_addr !== 8'h10) begin
            failures++;
            $display("FAIL single_issue got valid=%b addr=%h exp 1/10", lite_ar_valid, lite_ar_addr);
        end
        cycle_model("single_issue", s);
        lite_ar_ready = 1'b0;
        lite_r_valid  = 1'b1;
        lite_r_data   = 32'hDEADBEEF;
        m_r_ready     = 2'b01;
        #1;
        checks++;
        if (m_r_valid !== 2'b01 || m_r_data[DW-1:0] !== 32'hDEADBEEF || lite_r_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_r got rvalid=%b data=%h rready=%b exp 01/deadbeef/1", m_r_valid, m_r_data[DW-1:0], lite_r_ready);
        end
        @(posedge clk);
        void'(mq_m.pop_front()); void'(mq_a.pop_front()); void'(sq.pop_front());
        @(negedge clk);
        lite_r_valid = 1'b0;
        m_ar_valid   = '0;
        drive_r(1'b0, '1);
        cycle_model("single_after", s);
    endtask

    task automatic test_contention();
        logic [NM-1:0] s;
        int got[$];
`ifdef NASTI_LITE_ARB_FIXED_PRIO_EN
        int exp_seq[4] = '{0, 0, 0, 0};
`else
        int exp_seq[4] = '{0, 1, 0, 1};
`endif
        apply_reset();
        lite_ar_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_payload();
            m_ar_valid = 2'b11;
            drive_r(1'b1, '1);
            cycle_model("contention", s);
            if (s != '0) got.push_back(onehot_idx(s));
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL contention_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] != exp_seq[i]) begin
                    failures++;
                    $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, got[i], exp_seq[i]);
                end
            end
        end
        drain();
    endtask

    task automatic test_outstanding_limit();
        logic [NM-1:0] s;
        int n;
        n = 0;
        lite_ar_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rand_payload();
            m_ar_valid = 2'b01;
            drive_r(1'b0, '1);
            cycle_model("limit_fill", s);
            if (s != '0) n++;
        end
        checks++;
        if (n != MT) begin
            failures++;
            $display("FAIL limit_grants got=%0d exp=%0d", n, MT);
        end
        drive_r(1'b1, '1);
        cycle_model("limit_release", s);
        checks++;
        if (s !== '0) begin
            failures++;
            $display("FAIL limit_same_cycle got=%b exp=00", s);
        end
        drive_r(1'b0, '1);
        cycle_model("limit_next", s);
        checks++;
        if (s !== 2'b01) begin
            failures++;
            $display("FAIL limit_next_grant got=%b exp=01", s);
        end
        drain();
    endtask

    task automatic test_r_backpressure();
        logic [NM-1:0] s;
        rand_payload();
        m_ar_valid    = 2'b10;
        lite_ar_ready = 1'b1;
        drive_r(1'b0, '1);
        cycle_model("bp_grant", s);
        m_ar_valid = '0;
        cycle_model("bp_issue", s);
        for (int c = 0; c < 3; c++) begin
            drive_r(1'b1, 2'b01);
            #1;
            checks++;
            if (lite_r_ready !== 1'b0 || m_r_valid !== 2'b10) begin
                failures++;
                $display("FAIL bp_hold got rready=%b rvalid=%b exp 0/10", lite_r_ready, m_r_valid);
            end
            cycle_model("bp_hold", s);
        end
        drive_r(1'b1, 2'b11);
        #1;
        checks++;
        if (lite_r_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got rready=%b exp 1", lite_r_ready);
        end
        cycle_model("bp_release", s);
        drive_r(1'b0, '1);
        cycle_model("bp_after", s);
        checks++;
        if (m_r_valid !== '0) begin
            failures++;
            $display("FAIL bp_popped got rvalid=%b exp 00", m_r_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [NM-1:0] s;
        lite_ar_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_payload();
            m_ar_valid = (c % 2 == 0) ? 2'b01 : 2'b00;
            drive_r(1'b0, '1);
            cycle_model("mid_fill", s);
        end
        apply_reset();
        rand_payload();
        m_ar_valid = 2'b11;
        drive_r(1'b0, '1);
        cycle_model("mid_regrant", s);
        checks++;
        if (s !== 2'b01) begin
            failures++;
            $display("FAIL mid_reset_grant got=%b exp=01", s);
        end
        drain();
    endtask

    task automatic test_random();
        logic [NM-1:0] s;
        for (int c = 0; c < 400; c++) begin
            rand_payload();
            m_ar_valid    = NM'($urandom);
            lite_ar_ready = ($urandom % 4) != 0;
            drive_r(($urandom % 3) != 0, NM'($urandom));
            cycle_model("random", s);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        m_ar_valid = '0; lite_ar_ready = 1'b0; lite_r_valid = 1'b0; m_r_ready = '0;
        rand_payload();
        drive_r(1'b0, '0);
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_outstanding_limit();
        test_r_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nasti_lite_read_arbiter.md
Name: nasti_lite_read_arbiter

Overview:
- Shares one NASTI-Lite read slave between NUM_MASTERS NASTI-Lite read masters.
- Typical placement: between several lite masters (debug, DMA, host) and a single nasti_lite_reader-side slave port.
- AR requests are granted round-robin and issued through a registered output slot.
- R beats are returned in order to the issuing master, routed by an in-order grant FIFO (one R beat per lite transaction).

Parameters:
- NUM_MASTERS, 2, number of requesting lite masters (2..8).
- MAX_TRANSACTION, 4, maximum outstanding reads at the slave; grant FIFO depth (power of 2).
- ID_WIDTH, 1, id width per master and at the slave.
- ADDR_WIDTH, 8, address width.
- LITE_DATA_WIDTH, 32, read data width.
- USER_WIDTH, 1, user field width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_ar_id  in  NUM_MASTERS*ID_WIDTH  per-master AR id; master i occupies slice i
- m_ar_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master AR address
- m_ar_prot  in  NUM_MASTERS*3  per-master AR prot
- m_ar_qos  in  NUM_MASTERS*4  per-master AR qos
- m_ar_region  in  NUM_MASTERS*4  per-master AR region
- m_ar_user  in  NUM_MASTERS*USER_WIDTH  per-master AR user
- m_ar_valid  in  NUM_MASTERS  per-master AR valid
- m_ar_ready  out  NUM_MASTERS  per-master AR ready
- m_r_id  out  NUM_MASTERS*ID_WIDTH  R id, broadcast to all masters
- m_r_data  out  NUM_MASTERS*LITE_DATA_WIDTH  R data, broadcast
- m_r_resp  out  NUM_MASTERS*2  R resp, broadcast
- m_r_user  out  NUM_MASTERS*USER_WIDTH  R user, broadcast
- m_r_valid  out  NUM_MASTERS  per-master R valid; only the routed master sees it
- m_r_ready  in  NUM_MASTERS  per-master R ready
- lite_ar_id / addr / prot / qos / region / user  out  ID_WIDTH / ADDR_WIDTH / 3 / 4 / 4 / USER_WIDTH  slave AR payload
- lite_ar_valid  out  1  slave AR valid
- lite_ar_ready  in  1  slave AR ready
- lite_r_id / data / resp / user  in  ID_WIDTH / LITE_DATA_WIDTH / 2 / USER_WIDTH  slave R payload
- lite_r_valid  in  1  slave R valid
- lite_r_ready  out  1  slave R ready

Behaviour:
- Clock and reset: single clock clk; rstn asynchronous, active-low.
- Reset values:
  - lite_ar_valid=0, AR payload registers=0.
  - m_ar_ready=0.
  - FIFO empty; outstanding count=0; round-robin pointer=0.
  - m_r_valid=0, lite_r_ready=0.
- AR slot FSM:
  - EMPTY: grant is allowed when any m_ar_valid=1 and outstanding<MAX_TRANSACTION.
    - Winner is the first valid master at or after the pointer (cyclic).
    - m_ar_ready[winner]=1 in the same cycle (combinational); all other ready bits are 0.
    - On that edge: latch the winner's payload, push the winner index into the FIFO, increment outstanding, set pointer=winner+1 mod NUM_MASTERS, go to FULL.
  - FULL: lite_ar_valid=1 and payload is held stable; all m_ar_ready=0. On lite_ar_ready, go to EMPTY.
  - Throughput: at most one AR per 2 cycles. Grant latency: lite_ar_valid asserts 1 cycle after the m_ar handshake.
- R routing (combinational):
  - FIFO non-empty with head h: m_r_valid[h]=lite_r_valid; lite_r_ready=m_r_ready[h]; all other m_r_valid bits are 0.
  - FIFO empty: lite_r_ready=0. A slave must not return unrequested data; the block never acknowledges it.
  - On an R handshake: pop the FIFO and decrement outstanding.
- Boundary conditions:
  - Simultaneous grant and R handshake in one cycle: push and pop both happen; outstanding is unchanged.
  - outstanding==MAX_TRANSACTION: no grant. A completing R in that cycle does not enable a grant until the next cycle.
  - Pointer wraps from NUM_MASTERS-1 to 0.
  - Reset mid-operation: all state is discarded immediately; in-flight transactions are lost.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 grants.

Optional Feature:
- Macro: NASTI_LITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is held at 0 and never updated.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single request: m_ar_valid=01, addr 0x10 on master0 -> m_ar_ready=01 at cycle 0; lite_ar_valid=1 with addr 0x10 at cycle 1; lite R data 0xDEADBEEF -> m_r_valid=01 carrying 0xDEADBEEF.
- Contention: both masters held valid, slave always ready -> grants alternate M0,M1,M0,M1; R beats return to masters 0,1,0,1 in order.
- Outstanding limit: MAX_TRANSACTION=4, slave R withheld -> exactly 4 grants, then m_ar_ready=0; one R handshake -> the next grant occurs the following cycle.
- R backpressure: m_r_ready[1]=0 while head=1 -> lite_r_ready=0 and the FIFO does not pop; raising m_r_ready[1] -> handshake and pop.
- Reset with 2 outstanding: rstn low for 1 cycle -> lite_ar_valid=0, all m_r_valid=0, count=0; a new request is then granted starting from M0.
- With NASTI_LITE_ARB_FIXED_PRIO_EN: both masters held valid -> M0 is granted every time; M1 is never granted.
